// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter branch sequencer.
// State encoding and branch-target register chip-select levels.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      BR_SEL  = 2'd2,
      BR_LOAD = 2'd3
   } state_t;

   localparam logic CS_DRIVE   = 1'b0;
   localparam logic CS_RELEASE = 1'b1;

   // The branch-target register owns the bus only in the two branch states.
   function automatic logic bus_owned(input state_t s);
      return (s == BR_SEL) || (s == BR_LOAD);
   endfunction

endpackage

// File: rtl/pc_branch_sequencer_if.sv
// Fetch handshake and branch-target bus between the sequencer,
// instruction memory and the branch-target register.
interface pc_branch_sequencer_if #(
   parameter int NrOfBits = 16
);

   logic [NrOfBits-1:0] fetch_addr;
   logic                fetch_valid;
   logic                fetch_ready;
   logic [NrOfBits-1:0] br_bus;
   logic                br_cs;

   modport master (
      output fetch_addr,
      output fetch_valid,
      output br_cs,
      input  fetch_ready,
      input  br_bus
   );

   modport slave (
      input  fetch_addr,
      input  fetch_valid,
      input  br_cs,
      output fetch_ready,
      output br_bus
   );

endinterface

// File: rtl/pc_counter_reg.sv
// Program counter register: clear to reset vector, parallel load,
// or advance by a fixed step with natural wrap at 2^NrOfBits.
module pc_counter_reg #(
   parameter int NrOfBits    = 16,
   parameter int StepSize    = 1,
   parameter int ResetVector = 0
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_clear,
   input  logic                i_load,
   input  logic [NrOfBits-1:0] i_load_value,
   input  logic                i_inc,
   output logic [NrOfBits-1:0] o_value
);

   localparam logic [NrOfBits-1:0] RST_VAL =
      NrOfBits'(ResetVector);
   localparam logic [NrOfBits-1:0] STEP =
      NrOfBits'(StepSize);

   logic [NrOfBits-1:0] r_pc;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc <= RST_VAL;
      end else if (i_clear) begin
         r_pc <= RST_VAL;
      end else if (i_load) begin
         r_pc <= i_load_value;
      end else if (i_inc) begin
         r_pc <= r_pc + STEP;
      end
   end

   assign o_value = r_pc;

endmodule

// File: rtl/pc_branch_sequencer.sv
// Program-counter sequencer: issues fetch addresses and redirects
// fetch by reading the branch-target register off the shared bus.
module pc_branch_sequencer
   import pc_seq_pkg::*;
#(
   parameter int NrOfBits    = 16,
   parameter int StepSize    = 1,
   parameter int ResetVector = 0
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_tick,
   input  logic                         i_run,
   input  logic                         i_stall,
   input  logic                         i_branch_req,
   pc_branch_sequencer_if.master        io_bus,
   output logic                         o_redirect,
   output logic                         o_busy
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_pending;
   logic                w_pending_nxt;
   logic                w_branch;
   logic                w_hs;
   logic                w_pc_clear;
   logic                w_pc_load;
   logic                w_pc_inc;
   logic [NrOfBits-1:0] w_pc;

   pc_counter_reg #(
      .NrOfBits    (NrOfBits),
      .StepSize    (StepSize),
      .ResetVector (ResetVector)
   ) u_pc (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clear      (w_pc_clear),
      .i_load       (w_pc_load),
      .i_load_value (io_bus.br_bus),
      .i_inc        (w_pc_inc),
      .o_value      (w_pc)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_pending <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
      end
   end

   // FetchValid is high throughout FETCH, so ready alone completes it.
   assign w_hs     = io_bus.fetch_ready;
   assign w_branch = (r_pending | i_branch_req) & ~i_stall;

   always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = r_pending;
      w_pc_clear    = 1'b0;
      w_pc_load     = 1'b0;
      w_pc_inc      = 1'b0;
      if (i_tick) begin
         unique case (r_state)
            IDLE: begin
               w_pending_nxt = 1'b0;
               w_pc_clear    = 1'b1;
               if (i_run) begin
                  w_state_nxt = FETCH;
               end
            end
            FETCH: begin
               w_pending_nxt = r_pending | i_branch_req;
               if (w_branch) begin
                  w_state_nxt = BR_SEL;
               end else if (!i_run && w_hs) begin
                  w_state_nxt   = IDLE;
                  w_pending_nxt = 1'b0;
                  w_pc_clear    = 1'b1;
               end else if (w_hs && !i_stall) begin
                  w_pc_inc = 1'b1;
               end
            end
            // Turnaround cycle: register drives, bus not yet sampled.
            BR_SEL: begin
               w_pending_nxt = 1'b0;
               w_state_nxt   = BR_LOAD;
            end
            BR_LOAD: begin
               w_pc_load   = 1'b1;
               w_state_nxt = FETCH;
            end
         endcase
      end
   end

   assign io_bus.fetch_addr  = w_pc;
   assign io_bus.fetch_valid = (r_state == FETCH);
   assign io_bus.br_cs       = bus_owned(r_state) ? CS_DRIVE
                                                  : CS_RELEASE;
   assign o_redirect         = (r_state == BR_LOAD);
   assign o_busy             = (r_state != IDLE);

endmodule
